// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass, pending scoreboard and soft-clear sequencer.
// Optional debug read port enabled by defining REGFILE_DBG_EN.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop
`ifdef REGFILE_DBG_EN
  ,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_drop_q, wr_drop_d;

  logic [AW-1:0]    ra;
  logic             hit;

  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;

  always_comb begin
    regs_d    = regs_q;
    pend_d    = pend_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = we && (wr_addr != '0) && busy;
    case (state_q)
      IDLE: begin
        if (we && (wr_addr != '0)) begin
          regs_d[wr_addr] = wr_data;
          pend_d[wr_addr] = 1'b0;
        end
        // Issue is applied after the write-clear so a same-address set wins.
        if (iss_en && (iss_addr != '0)) begin
          pend_d[iss_addr] = 1'b1;
        end
        if (clr_req) begin
          pend_d  = '0;
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      default: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // rst_n gates the read path so a bypass hit cannot leak data during reset.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra  = rd_addr[k*AW +: AW];
      hit = (BYPASS != 0) && we && (wr_addr == ra);
      if (rst_n && rd_en[k] && (ra != '0) && !busy) begin
        rd_data[k*XLEN +: XLEN] = hit ? wr_data : regs_q[ra];
        rd_pend[k]              = pend_q[ra] && !hit;
      end
    end
  end

`ifdef REGFILE_DBG_EN
  logic [XLEN-1:0] dbg_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= regs_q[dbg_addr];
    end
  end

  assign dbg_data = dbg_data_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural register-file model.
// Two instances share stimulus: one with write bypass, one without.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        clr_req;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic        busy, busy_nb, wr_drop, wr_drop_nb;
`ifdef REGFILE_DBG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data, dbg_data_nb;
`endif

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .busy(busy),
    .wr_drop(wr_drop)
`ifdef REGFILE_DBG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pend(rd_pend_nb),
    .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .busy(busy_nb),
    .wr_drop(wr_drop_nb)
`ifdef REGFILE_DBG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
`endif
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: plain arrays plus the number of clear cycles still to run.
  logic [31:0] mreg [32];
  bit          mpend [32];
  int          clr_left;
  bit          mdrop;
  logic [31:0] mdbg;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
    clr_left = 0;
    mdrop    = 1'b0;
    mdbg     = '0;
  endtask

  task automatic model_update();
`ifdef REGFILE_DBG_EN
    mdbg = mreg[dbg_addr];
`endif
    if (clr_left > 0) begin
      mreg[32 - clr_left] = '0;
      clr_left--;
      mdrop = we && (wr_addr != 0);
    end else begin
      mdrop = 1'b0;
      if (we && wr_addr != 0) begin
        mreg[wr_addr]  = wr_data;
        mpend[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) mpend[iss_addr] = 1'b1;
      if (clr_req) begin
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        clr_left = 31;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k, input bit byp);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    if (!rst_n || !rd_en[k] || a == 0 || clr_left > 0) return '0;
    if (byp && we && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_pend(input int k, input bit byp);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    if (!rst_n || !rd_en[k] || a == 0 || clr_left > 0) return 1'b0;
    if (byp && we && wr_addr == a) return 1'b0;
    return mpend[a];
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_data%0d", k), 64'(rd_data[k*32 +: 32]), 64'(exp_rd(k, 1'b1)));
      chk($sformatf("rd_data_nb%0d", k), 64'(rd_data_nb[k*32 +: 32]), 64'(exp_rd(k, 1'b0)));
      chk($sformatf("rd_pend%0d", k), 64'(rd_pend[k]), 64'(exp_pend(k, 1'b1)));
      chk($sformatf("rd_pend_nb%0d", k), 64'(rd_pend_nb[k]), 64'(exp_pend(k, 1'b0)));
    end
    chk("busy", 64'(busy), 64'(clr_left > 0));
    chk("busy_nb", 64'(busy_nb), 64'(clr_left > 0));
    chk("wr_drop", 64'(wr_drop), 64'(mdrop));
`ifdef REGFILE_DBG_EN
    chk("dbg_data", 64'(dbg_data), 64'(mdbg));
`endif
  endtask

  // Called at posedge+1; checks before the edge, then advances the model with the sampled inputs.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; iss_en = 1'b0; clr_req = 1'b0; rd_en = '0;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom % 2 == 0) ? 5'($urandom % 8) : 5'($urandom % 32);
  endfunction

  int nbusy, ndrop;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    wr_addr = '0; wr_data = '0; rd_addr = '0; iss_addr = '0;
`ifdef REGFILE_DBG_EN
    dbg_addr = '0;
`endif
    model_reset();
    @(posedge clk); #1;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd1};
    tick(); tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // Write then read x5, then with the port disabled
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
    we = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    #2 chk("wr_rd_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    tick();
    rd_en = 2'b00;
    #2 chk("rd_en_off", 64'(rd_data[31:0]), 64'h0);
    tick();

    // x0 is hardwired; a write there is not a drop
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_en = 2'b01; rd_addr = '0; tick();
    we = 1'b0;
    #2 chk("x0_read", 64'(rd_data[31:0]), 64'h0);
    chk("x0_no_drop", 64'(wr_drop), 64'h0);
    tick();

    // Same-cycle bypass
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111; tick();
    wr_data = 32'hCAFE; rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    #2 chk("bypass", 64'(rd_data), {32'hCAFE, 32'hCAFE});
    chk("no_bypass", 64'(rd_data_nb), {32'h1111, 32'h1111});
    tick();
    idle_inputs();

    // Scoreboard
    iss_en = 1'b1; iss_addr = 5'd3; tick();
    iss_en = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    #2 chk("pend_set", 64'(rd_pend[0]), 64'h1);
    tick();
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; tick();
    we = 1'b0;
    #2 chk("pend_clr", 64'(rd_pend[0]), 64'h0);
    tick();
    we = 1'b1; iss_en = 1'b1; tick();
    we = 1'b0; iss_en = 1'b0;
    #2 chk("pend_set_wins", 64'(rd_pend[0]), 64'h1);
    tick();

    // Soft clear with a dropped write in its 4th cycle
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr_addr = 5'(i); wr_data = $urandom | 32'h1; tick();
    end
    we = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    nbusy = 0; ndrop = 0;
    for (int j = 0; j < 40; j++) begin
      if (busy) nbusy++;
      we = (j == 3); wr_addr = 5'd9; wr_data = 32'h99;
      rd_en = 2'b11; rd_addr = {rand_addr(), rand_addr()};
      tick();
      if (wr_drop) ndrop++;
    end
    we = 1'b0;
    chk("busy_len", 64'(nbusy), 64'd31);
    chk("drop_count", 64'(ndrop), 64'd1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 2'b11; rd_addr = {5'(2*i+1), 5'(2*i)};
      #2 chk("clr_zero", rd_data, 64'h0);
      tick();
    end

    // Asynchronous reset in the 10th clear cycle
    we = 1'b1; wr_addr = 5'd20; wr_data = 32'h2020; tick();
    we = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    rd_en = 2'b11; rd_addr = {5'd20, 5'd25}; we = 1'b1; wr_addr = 5'd20; wr_data = 32'hBAD;
    #1 rst_n = 1'b0;
    #1 chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_rd_data", rd_data, 64'h0);
    chk("arst_rd_pend", 64'(rd_pend), 64'h0);
    model_reset();
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1; we = 1'b0;
    tick();
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'h55; tick();
    we = 1'b0; rd_en = 2'b01; rd_addr = {5'd0, 5'd2};
    #2 chk("post_arst_x2", 64'(rd_data[31:0]), 64'h55);
    chk("post_arst_idle", 64'(busy), 64'h0);
    tick();

`ifdef REGFILE_DBG_EN
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'hA5A5A5A5; tick();
    we = 1'b0; dbg_addr = 5'd12; tick();
    chk("dbg_idle", 64'(dbg_data), 64'hA5A5A5A5);
    clr_req = 1'b1; tick();
    clr_req = 1'b0; tick();
    chk("dbg_busy", 64'(dbg_data), 64'hA5A5A5A5);
    for (int j = 0; j < 40 && clr_left > 0; j++) tick();
`endif

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      we       = $urandom % 2;
      wr_addr  = rand_addr();
      wr_data  = $urandom;
      rd_en    = 2'($urandom);
      rd_addr  = {rand_addr(), rand_addr()};
      iss_en   = ($urandom % 3 == 0);
      iss_addr = rand_addr();
      clr_req  = ($urandom % 150 == 0);
`ifdef REGFILE_DBG_EN
      dbg_addr = rand_addr();
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
